aes_round_key_gen: RTL
======================

// Module: aes_round_key_gen
// PURPOSE
//   Parametrised round-key sequencer for the toy AES datapath. Loads a master key, then
//   steps forward (encrypt) or backward (decrypt) through NUM_ROUNDS+1 round keys under
//   a start/step/abort handshake. Registered outputs only; sits beside the round core.
// PARAMETERS
//   KEY_W      128  round-key width in bits
//   LANES      2    independent rotate lanes; KEY_W % LANES == 0, LW = KEY_W/LANES
//   ROT        8    per-round rotation in bits, 0 < ROT < LW
//   NUM_ROUNDS 8    round transitions; keys indexed 0..NUM_ROUNDS
//   RW         $clog2(NUM_ROUNDS+1)  round index width (derived localparam)
// PORTS
//   clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   key_in     in   KEY_W  master key, sampled only on accepted start
//   encdec     in   1      1 = encrypt (ascending), 0 = decrypt (descending); sampled with start
//   start      in   1      load key_in and begin a schedule; honoured only in IDLE
//   step       in   1      advance one round; honoured only when ready=1
//   abort      in   1      return to IDLE from any state; highest priority
//   busy       out  1      1 in PRECOMP or ACTIVE
//   ready      out  1      1 in ACTIVE: round_key/round_idx valid
//   round_key  out  KEY_W  current round key (registered)
//   round_idx  out  RW     index of round_key
//   last       out  1      ready && (enc ? round_idx==NUM_ROUNDS : round_idx==0)
//   done       out  1      one-cycle pulse after step accepted while last=1
// BEHAVIOUR
//   - Reset: state=IDLE; key_reg, round_idx, cnt, busy, ready, last, done = 0.
//   - fwd(k): each LW-bit lane rotated right by ROT; inv(k): each lane rotated left by ROT.
//   - IDLE: start -> key_reg=key_in, mode=encdec. Enc: ACTIVE, round_idx=0 (ready next cycle).
//     Dec: PRECOMP, cnt=0.
//   - PRECOMP: each cycle key_reg=fwd(key_reg), cnt++. On the cycle cnt==NUM_ROUNDS-1:
//     -> ACTIVE, round_idx=NUM_ROUNDS. ready rises NUM_ROUNDS+1 cycles after start.
//   - ACTIVE, step, !last: enc key_reg=fwd, round_idx+1; dec key_reg=inv, round_idx-1.
//     Outputs update next cycle, 1-cycle step latency, back-to-back steps every cycle.
//   - ACTIVE, step, last: -> IDLE, done=1 for exactly one cycle, ready=0.
//   - ACTIVE, no step: all outputs hold.
//   - abort: any state -> IDLE next cycle; no done pulse; wins over simultaneous start/step.
//   - start outside IDLE is ignored. step outside ACTIVE is ignored.
//   - start with step in the same IDLE cycle: start taken, step dropped.
//   - round_idx never wraps; it stays within 0..NUM_ROUNDS.
//   - Reset asserted mid-schedule clears everything at once, as at power-up.
// CONFIGURATION
//   AES_RKG_ZEROIZE_EN defined: key_reg and round_key are cleared to 0 in the cycle
//     that IDLE is entered via done or abort.
//   AES_RKG_ZEROIZE_EN undefined: key_reg and round_key keep the last value after
//     done/abort. round_idx holds too. Outputs are not reset except by reset_n.
// TESTING  (KEY_W=128, LANES=2, ROT=8, NUM_ROUNDS=8, K=0x0001020304050607_08090a0b0c0d0e0f)
//   1. Reset mid-PRECOMP -> all outputs 0 asynchronously. After release, state IDLE, busy=0.
//   2. Enc start K, one step -> idx0 key=K; idx1 key=0x0700010203040506_0f08090a0b0c0d0e.
//      8 more steps -> last at idx8, key==K (64-bit lane identity), then done pulse.
//   3. Dec start K -> busy 8 cycles; ready on cycle 9 with idx=8, key=K.
//      step -> idx7 key=0x0102030405060700_090a0b0c0d0e0f08.
//   4. Dec full run, step every cycle -> idx 8..0, last at idx0.
//      Next step gives a single-cycle done, ready=0.
//   5. abort during PRECOMP and during ACTIVE, abort+step same cycle -> IDLE next cycle, no done.
//      With ZEROIZE round_key=0; without ZEROIZE round_key holds.
//   6. start while ACTIVE with a new key -> ignored, round_key/round_idx unchanged.
//      step while IDLE -> no change.

Source files
------------

// File: rtl/aes_round_key_gen.sv
// rtl/aes_round_key_gen.sv - round-key sequencer: lane rotations forward (encrypt) or backward (decrypt).
// Optional AES_RKG_ZEROIZE_EN clears the key register on done or abort.
module aes_round_key_gen #(
  parameter int KEY_W      = 128,
  parameter int LANES      = 2,
  parameter int ROT        = 8,
  parameter int NUM_ROUNDS = 8,
  localparam int RW        = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             encdec,
  input  logic             start,
  input  logic             step,
  input  logic             abort,
  output logic             busy,
  output logic             ready,
  output logic [KEY_W-1:0] round_key,
  output logic [RW-1:0]    round_idx,
  output logic             last,
  output logic             done
);

  localparam int LW = KEY_W / LANES;
  localparam logic [RW-1:0] IDX_MAX = RW'(NUM_ROUNDS);
  localparam logic [RW-1:0] CNT_END = RW'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, PRECOMP, ACTIVE} state_t;

  state_t          state;
  logic [KEY_W-1:0] key_reg;
  logic [RW-1:0]   cnt;
  logic            enc;

  function automatic logic [KEY_W-1:0] fwd(input logic [KEY_W-1:0] k);
    logic [LW-1:0] lane;
    fwd = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = k[i*LW +: LW];
      fwd[i*LW +: LW] = (lane >> ROT) | (lane << (LW - ROT));
    end
  endfunction

  function automatic logic [KEY_W-1:0] inv(input logic [KEY_W-1:0] k);
    logic [LW-1:0] lane;
    inv = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = k[i*LW +: LW];
      inv[i*LW +: LW] = (lane << ROT) | (lane >> (LW - ROT));
    end
  endfunction

  assign round_key = key_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      cnt       <= '0;
      enc       <= 1'b0;
      round_idx <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        ready <= 1'b0;
        last  <= 1'b0;
`ifdef AES_RKG_ZEROIZE_EN
        key_reg <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              key_reg <= key_in;
              enc     <= encdec;
              busy    <= 1'b1;
              if (encdec) begin
                state     <= ACTIVE;
                round_idx <= '0;
                ready     <= 1'b1;
                last      <= 1'b0;
              end else begin
                state <= PRECOMP;
                cnt   <= '0;
              end
            end
          end
          // Decrypt starts from the final round key, so roll the master key forward first.
          PRECOMP: begin
            key_reg <= fwd(key_reg);
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_END) begin
              state     <= ACTIVE;
              round_idx <= IDX_MAX;
              ready     <= 1'b1;
              last      <= 1'b0;
            end
          end
          ACTIVE: begin
            if (step) begin
              if (last) begin
                state <= IDLE;
                busy  <= 1'b0;
                ready <= 1'b0;
                last  <= 1'b0;
                done  <= 1'b1;
`ifdef AES_RKG_ZEROIZE_EN
                key_reg <= '0;
`endif
              end else if (enc) begin
                key_reg   <= fwd(key_reg);
                round_idx <= round_idx + 1'b1;
                last      <= (round_idx == IDX_MAX - 1'b1);
              end else begin
                key_reg   <= inv(key_reg);
                round_idx <= round_idx - 1'b1;
                last      <= (round_idx == RW'(1));
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
